sort_selftest_harness: RTL

//  Synthesisable self-checking harness for sort_circuit on a shared memory bus.
//  - Fills memory with LFSR data over AW/W/B.
//  - Hands the bus to the sorter and starts it.
//  - Reads the array back over AR/R and checks it is in non-decreasing order.
//  - Reports pass/fail, a fail code and an error count.

---
 rtl/sort_harness_pkg.sv | 27 ++
 rtl/sort_selftest_harness_lfsr.sv | 21 ++
 rtl/sort_selftest_harness.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_harness_pkg.sv
// Shared encodings for the sort self-test harness: FSM states, sub-phases,
// fail codes and the OK response value.
package sort_harness_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Per-word bus sub-phases shared by FILL and CHECK.
  localparam logic [1:0] PH_NEXT = 2'd0;
  localparam logic [1:0] PH_REQ  = 2'd1;
  localparam logic [1:0] PH_RESP = 2'd2;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_BAD_SIZE = 3'd1;
  localparam logic [2:0] FC_BUS_ERR  = 3'd2;
  localparam logic [2:0] FC_SORT_ERR = 3'd3;
  localparam logic [2:0] FC_TIMEOUT  = 3'd4;
  localparam logic [2:0] FC_ORDER    = 3'd5;
  localparam logic [2:0] FC_CKSUM    = 3'd6;

  localparam int RESP_OK = 0;

endpackage

// File: rtl/sort_selftest_harness_lfsr.sv
// Right-shifting Galois LFSR that produces the fill pattern; advances only
// when step is high so the sequence continues across runs.
module lfsr_gen #(
  parameter int DATA_WDTH = 32,
  parameter logic [DATA_WDTH-1:0] SEED = 1,
  parameter logic [DATA_WDTH-1:0] TAPS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [DATA_WDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= SEED;
    else if (step)
      value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
  end

endmodule

// File: rtl/sort_selftest_harness.sv
// Self-checking harness: fills memory with LFSR data, runs the external sorter,
// reads back and checks ordering. Optional checksum check: SORT_CKSUM_EN.
module sort_selftest_harness
  import sort_harness_pkg::*;
#(
  parameter int          ADDR_WDTH   = 4,
  parameter int          DATA_WDTH   = 32,
  parameter int          RESP_WDTH   = 1,
  parameter logic [31:0] LFSR_SEED   = 32'h1,
  parameter logic [31:0] LFSR_TAPS   = 32'hB4BCD35C,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_WDTH:0]   arr_size,
  output logic                 bus_sel,
  output logic                 sort_start,
  input  logic                 sort_done,
  input  logic                 sort_err,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [2:0]           fail_code,
  output logic [ADDR_WDTH:0]   err_count
);

  localparam int CNT_W = ADDR_WDTH + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(2**ADDR_WDTH);
`ifdef SORT_CKSUM_EN
  localparam int SUM_W = DATA_WDTH + ADDR_WDTH;
`endif

  logic [2:0]           state;
  logic [1:0]           phase;
  logic [CNT_W-1:0]     n_elem;
  logic [CNT_W-1:0]     idx;
  logic [TMR_W-1:0]     tmr;
  logic [DATA_WDTH-1:0] prev_data;
  logic [DATA_WDTH-1:0] lfsr_value;
  logic                 lfsr_step;
  logic                 b_ok;
  logic                 r_ok;
  logic                 last_idx;
`ifdef SORT_CKSUM_EN
  logic [SUM_W-1:0]     wr_sum;
  logic [SUM_W-1:0]     rd_sum;
`endif

  assign b_ok      = (b_resp == RESP_WDTH'(RESP_OK));
  assign r_ok      = (r_resp == RESP_WDTH'(RESP_OK));
  assign last_idx  = (idx == n_elem - CNT_W'(1));
  assign lfsr_step = (state == ST_FILL) && (phase == PH_RESP) && b_valid && b_ready && b_ok;

  lfsr_gen #(
    .DATA_WDTH (DATA_WDTH),
    .SEED      (DATA_WDTH'(LFSR_SEED)),
    .TAPS      (DATA_WDTH'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_NEXT;
      n_elem     <= '0;
      idx        <= '0;
      tmr        <= '0;
      prev_data  <= '0;
      bus_sel    <= 1'b0;
      sort_start <= 1'b0;
      ar_valid   <= 1'b0;
      ar_address <= '0;
      r_ready    <= 1'b0;
      aw_valid   <= 1'b0;
      aw_address <= '0;
      w_valid    <= 1'b0;
      w_data     <= '0;
      b_ready    <= 1'b0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= FC_NONE;
      err_count  <= '0;
`ifdef SORT_CKSUM_EN
      wr_sum     <= '0;
      rd_sum     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            n_elem    <= arr_size;
            idx       <= '0;
            phase     <= PH_NEXT;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            err_count <= '0;
            busy      <= 1'b1;
`ifdef SORT_CKSUM_EN
            wr_sum    <= '0;
            rd_sum    <= '0;
`endif
            if (arr_size > MAX_N) begin
              fail      <= 1'b1;
              fail_code <= FC_BAD_SIZE;
              state     <= ST_DONE;
            end else if (arr_size == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          case (phase)
            PH_NEXT: begin
              aw_valid   <= 1'b1;
              w_valid    <= 1'b1;
              aw_address <= idx[ADDR_WDTH-1:0];
              w_data     <= lfsr_value;
              phase      <= PH_REQ;
            end
            PH_REQ: begin
              // Each channel drops on its own handshake; B is awaited once both are in.
              aw_valid <= aw_valid & ~aw_ready;
              w_valid  <= w_valid & ~w_ready;
              if (!(aw_valid && !aw_ready) && !(w_valid && !w_ready)) begin
                b_ready <= 1'b1;
                phase   <= PH_RESP;
              end
`ifdef SORT_CKSUM_EN
              if (w_valid && w_ready)
                wr_sum <= wr_sum + SUM_W'(w_data);
`endif
            end
            PH_RESP: begin
              if (b_valid) begin
                b_ready <= 1'b0;
                phase   <= PH_NEXT;
                if (!b_ok) begin
                  fail      <= 1'b1;
                  fail_code <= FC_BUS_ERR;
                  state     <= ST_DONE;
                end else if (last_idx) begin
                  idx   <= '0;
                  state <= ST_START;
                end else begin
                  idx <= idx + CNT_W'(1);
                end
              end
            end
            default: phase <= PH_NEXT;
          endcase
        end

        ST_START: begin
          bus_sel    <= 1'b1;
          sort_start <= 1'b1;
          tmr        <= TMR_W'(TIMEOUT_CYC - 1);
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (sort_err) begin
            sort_start <= 1'b0;
            bus_sel    <= 1'b0;
            fail       <= 1'b1;
            fail_code  <= FC_SORT_ERR;
            state      <= ST_DONE;
          end else if (sort_done) begin
            sort_start <= 1'b0;
            bus_sel    <= 1'b0;
            phase      <= PH_NEXT;
            state      <= ST_CHECK;
          end else if (tmr == '0) begin
            sort_start <= 1'b0;
            bus_sel    <= 1'b0;
            fail       <= 1'b1;
            fail_code  <= FC_TIMEOUT;
            state      <= ST_DONE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        ST_CHECK: begin
          case (phase)
            PH_NEXT: begin
              ar_valid   <= 1'b1;
              ar_address <= idx[ADDR_WDTH-1:0];
              phase      <= PH_REQ;
            end
            PH_REQ: begin
              if (ar_ready) begin
                ar_valid <= 1'b0;
                r_ready  <= 1'b1;
                phase    <= PH_RESP;
              end
            end
            PH_RESP: begin
              if (r_valid) begin
                r_ready <= 1'b0;
                if (!r_ok) begin
                  fail      <= 1'b1;
                  fail_code <= FC_BUS_ERR;
                  state     <= ST_DONE;
                end else begin
                  if (idx != '0 && r_data < prev_data && err_count != '1)
                    err_count <= err_count + CNT_W'(1);
                  prev_data <= r_data;
`ifdef SORT_CKSUM_EN
                  rd_sum <= rd_sum + SUM_W'(r_data);
`endif
                  if (last_idx) begin
                    state <= ST_DONE;
                  end else begin
                    idx        <= idx + CNT_W'(1);
                    ar_valid   <= 1'b1;
                    ar_address <= idx[ADDR_WDTH-1:0] + ADDR_WDTH'(1);
                    phase      <= PH_REQ;
                  end
                end
              end
            end
            default: phase <= PH_NEXT;
          endcase
        end

        ST_DONE: begin
          bus_sel    <= 1'b0;
          sort_start <= 1'b0;
          ar_valid   <= 1'b0;
          r_ready    <= 1'b0;
          aw_valid   <= 1'b0;
          w_valid    <= 1'b0;
          b_ready    <= 1'b0;
          busy       <= 1'b0;
          phase      <= PH_NEXT;
          state      <= ST_IDLE;
          // An earlier abort has already latched fail and its code.
          if (!fail) begin
            if (err_count != '0) begin
              fail      <= 1'b1;
              fail_code <= FC_ORDER;
            end
`ifdef SORT_CKSUM_EN
            else if (wr_sum != rd_sum) begin
              fail      <= 1'b1;
              fail_code <= FC_CKSUM;
            end
`endif
            else begin
              pass <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
